io_tape_reader: RTL and testbench

//  Input device adapter (photo-reader model) feeding io_unit's input handshake.

---
 rtl/io_tape_reader.sv | 159 +++++++++++++++
 tb/tb_io_tape_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_tape_reader.sv
// rtl/io_tape_reader.sv - photo-reader tape input adapter: FIFO, 4-phase rdy/ack, inter-character gap
module io_tape_reader #(
    parameter int  DEPTH      = 16,
    parameter int  GAP_CYCLES = 4,
    parameter int  GAP_W      = 8,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [4:0]       host_data,
    output logic             input_rdy_to_io,
    input  logic             input_ack_from_io,
    output logic [4:0]       input_data_to_io,
    output logic [CNT_W-1:0] fifo_count,
    output logic             fifo_empty,
    output logic             protocol_err
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [3:0] R_IDLE = 4'b0001;
    localparam logic [3:0] R_RDY  = 4'b0010;
    localparam logic [3:0] R_ACK  = 4'b0100;
    localparam logic [3:0] R_GAP  = 4'b1000;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [4:0]       data_q, data_d;
    logic             err_q, err_d;
    logic             ack_d_q, ack_d_d;
    logic [4:0]       mem_q [DEPTH];
    logic [4:0]       mem_d [DEPTH];

    logic full;
    logic push;
    logic pop;

    // Ready comes from the registered count, so a pop while full only frees a slot next cycle.
    assign full       = (count_q == CNT_W'(DEPTH));
    assign host_ready = !full && !flush;
    assign push       = host_valid && host_ready;
    assign pop        = (state_q == R_RDY) && input_ack_from_io;

    assign input_rdy_to_io  = (state_q == R_RDY);
    assign input_data_to_io = data_q;
    assign fifo_count       = count_q;
    assign fifo_empty       = (count_q == '0);
    assign protocol_err     = err_q;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = host_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        gap_d    = gap_q;
        data_d   = data_q;
        err_d    = err_q;
        ack_d_d  = input_ack_from_io;

        if (flush) begin
            state_d  = R_IDLE;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            gap_d    = '0;
            err_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            // Only a rising ack outside R_RDY is a protocol fault; a held ack is not.
            if (input_ack_from_io && !ack_d_q && (state_q != R_RDY)) begin
                err_d = 1'b1;
            end

            case (state_q)
                R_IDLE: begin
                    if ((count_q != '0) && !input_ack_from_io) begin
                        state_d = R_RDY;
                        data_d  = mem_q[rd_ptr_q];
                    end
                end
                R_RDY: begin
                    if (input_ack_from_io) begin
                        state_d = R_ACK;
                    end
                end
                R_ACK: begin
                    if (!input_ack_from_io) begin
                        if (GAP_CYCLES == 0) begin
                            state_d = R_IDLE;
                        end else begin
                            state_d = R_GAP;
                            gap_d   = GAP_W'(GAP_CYCLES - 1);
                        end
                    end
                end
                R_GAP: begin
                    if (gap_q == '0) begin
                        state_d = R_IDLE;
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
                default: state_d = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= R_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            gap_q    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            ack_d_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            gap_q    <= gap_d;
            data_q   <= data_d;
            err_q    <= err_d;
            ack_d_q  <= ack_d_d;
        end
    end

    // Storage is never read before it is written, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_io_tape_reader.sv
// tb/tb_io_tape_reader.sv - directed self-checking bench for io_tape_reader
module tb_io_tape_reader;

    logic       clk = 1'b0;
    logic       resetn;
    logic       flush;
    logic       host_valid;
    logic       host_ready;
    logic [4:0] host_data;
    logic       rdy;
    logic       ack;
    logic [4:0] dout;
    logic [4:0] cnt;
    logic       fifo_empty;
    logic       perr;

    int cyc  = 0;
    int nvec = 0;
    int nerr = 0;

    int         r1, r2, r3;
    logic [4:0] c1, c2, c3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    io_tape_reader dut (
        .clk               (clk),
        .resetn            (resetn),
        .flush             (flush),
        .host_valid        (host_valid),
        .host_ready        (host_ready),
        .host_data         (host_data),
        .input_rdy_to_io   (rdy),
        .input_ack_from_io (ack),
        .input_data_to_io  (dout),
        .fifo_count        (cnt),
        .fifo_empty        (fifo_empty),
        .protocol_err      (perr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // io_unit model: ack lat cycles after rdy is seen, hold ack for 2 cycles.
    task automatic serve(input int lat, output int rise, output logic [4:0] code);
        int n = 0;
        while (rdy !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        chk("rdy_wait", rdy, 1);
        rise = cyc;
        code = dout;
        repeat (lat) tick;
        ack = 1'b1;
        repeat (2) tick;
        ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        flush      = 1'b0;
        host_valid = 1'b0;
        host_data  = 5'd0;
        ack        = 1'b0;
        repeat (2) tick;
        chk("rst_rdy", rdy, 0);
        chk("rst_data", dout, 0);
        chk("rst_count", cnt, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_ready", host_ready, 1);
        chk("rst_err", perr, 0);
        resetn = 1'b1;
        tick;

        // single code, io acks 3 cycles after rdy
        host_valid = 1'b1;
        host_data  = 5'b10011;
        tick;
        host_valid = 1'b0;
        chk("t2_count1", cnt, 1);
        chk("t2_rdy_t1", rdy, 0);
        tick;
        chk("t2_rdy_t2", rdy, 1);
        chk("t2_data", dout, 5'b10011);
        repeat (2) tick;
        chk("t2_rdy_hold", rdy, 1);
        ack = 1'b1;
        tick;
        chk("t2_rdy_after_ack", rdy, 0);
        chk("t2_count0", cnt, 0);
        tick;
        chk("t2_rdy_ack2", rdy, 0);
        ack = 1'b0;
        tick;
        repeat (6) tick;
        chk("t2_empty", fifo_empty, 1);
        chk("t2_err", perr, 0);

        // back-to-back codes, gap spacing = 2 + 1 + 4 + 1 + 3
        host_valid = 1'b1;
        host_data  = 5'b10001;
        tick;
        host_data  = 5'b00110;
        tick;
        host_data  = 5'b00111;
        tick;
        host_valid = 1'b0;
        serve(3, r1, c1);
        serve(3, r2, c2);
        serve(3, r3, c3);
        chk("t3_code1", c1, 5'b10001);
        chk("t3_code2", c2, 5'b00110);
        chk("t3_code3", c3, 5'b00111);
        chk("t3_space12", r2 - r1, 11);
        chk("t3_space23", r3 - r2, 11);
        repeat (8) tick;
        chk("t3_empty", fifo_empty, 1);
        chk("t3_rdy_idle", rdy, 0);

        // fill to 16 with no acks; 17th refused
        for (int i = 0; i < 17; i++) begin
            host_valid = 1'b1;
            host_data  = 5'(i + 3);
            tick;
        end
        host_data = 5'd31;
        chk("t4_count_full", cnt, 16);
        chk("t4_ready_full", host_ready, 0);
        chk("t4_head", dout, 5'd3);
        ack = 1'b1;
        tick;
        chk("t4_count_pop", cnt, 15);
        chk("t4_ready_after_pop", host_ready, 1);
        ack = 1'b0;
        tick;
        host_valid = 1'b0;
        chk("t4_count_refill", cnt, 16);
        chk("t4_ready_refill", host_ready, 0);

        // flush blocks ready, then flush in R_ACK with ack high
        flush = 1'b1;
        #1;
        chk("t5_ready_in_flush", host_ready, 0);
        tick;
        flush = 1'b0;
        chk("t5_count_flush", cnt, 0);
        chk("t5_empty_flush", fifo_empty, 1);
        for (int i = 0; i < 6; i++) begin
            host_valid = 1'b1;
            host_data  = 5'(i + 8);
            tick;
        end
        host_valid = 1'b0;
        chk("t5_count6", cnt, 6);
        chk("t5_rdy", rdy, 1);
        ack = 1'b1;
        tick;
        chk("t5_count5", cnt, 5);
        chk("t5_rdy_ack", rdy, 0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("t5_count_flush2", cnt, 0);
        chk("t5_rdy_flush2", rdy, 0);
        chk("t5_data_hold", dout, 5'd8);
        host_valid = 1'b1;
        host_data  = 5'b01010;
        tick;
        host_valid = 1'b0;
        chk("t5_count_new", cnt, 1);
        chk("t5_rdy_wait_ack", rdy, 0);
        tick;
        chk("t5_rdy_wait_ack2", rdy, 0);
        ack = 1'b0;
        tick;
        chk("t5_rdy_new", rdy, 1);
        chk("t5_data_new", dout, 5'b01010);
        chk("t5_err", perr, 0);
        ack = 1'b1;
        tick;
        ack = 1'b0;
        tick;
        repeat (6) tick;

        // stray ack pulse in R_IDLE
        ack = 1'b1;
        tick;
        ack = 1'b0;
        chk("t6_err_set", perr, 1);
        tick;
        chk("t6_err_sticky", perr, 1);
        host_valid = 1'b1;
        host_data  = 5'b00101;
        tick;
        host_valid = 1'b0;
        serve(1, r1, c1);
        chk("t6_code", c1, 5'b00101);
        chk("t6_err_traffic", perr, 1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("t6_err_clear", perr, 0);

        // async reset while rdy is high
        host_valid = 1'b1;
        host_data  = 5'b11100;
        tick;
        host_valid = 1'b0;
        tick;
        chk("t1_rdy_before", rdy, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t1_rdy_async", rdy, 0);
        chk("t1_data_async", dout, 0);
        chk("t1_count_async", cnt, 0);
        chk("t1_ready_async", host_ready, 1);
        #3;
        resetn = 1'b1;
        tick;
        chk("t1_rdy_release", rdy, 0);
        chk("t1_empty_release", fifo_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
